tone_sequencer: RTL and testbench

Parametrised multi-voice tone player: the next generation of the single-speaker music processor. Each of CHANNELS voices owns a small note queue loaded over a valid/ready write port. It plays queued notes gaplessly as square waves with millisecond durations, and mixes all voices onto one speaker bit. The block sits behind the tile top level, driving uo_out/uio_out; ui_in/uio_in supply the write port.

---
 rtl/tone_sequencer.sv | 172 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Multi-voice queued square-wave tone player mixed onto a single speaker bit.
// Optional replay mode is compiled in with `define TONE_SEQ_LOOP_EN.
module tone_sequencer #(
    parameter int CHANNELS        = 2,
    parameter int DEPTH           = 4,
    parameter int DIV_W           = 12,
    parameter int DUR_W           = 8,
    parameter int TICKS_PER_MILLI = 100
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              ena,
    input  logic                                              stop,
    input  logic                                              loop,
    input  logic                                              wr_valid,
    output logic                                              wr_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
    input  logic [DIV_W-1:0]                                  wr_half_period,
    input  logic [DUR_W-1:0]                                  wr_dur_ms,
    output logic [CHANNELS-1:0]                               tone,
    output logic [CHANNELS-1:0]                               busy,
    output logic                                              sound
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PRE_W = (TICKS_PER_MILLI > 1) ? $clog2(TICKS_PER_MILLI) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    logic [PRE_W-1:0]    presc;
    logic                ms_tick;
    logic                loop_active;
    logic                sel_full;
    logic [CHANNELS-1:0] full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (ena) begin
            if (presc == PRE_W'(TICKS_PER_MILLI - 1))
                presc <= '0;
            else
                presc <= presc + PRE_W'(1);
        end
    end

    assign ms_tick = ena && (presc == PRE_W'(TICKS_PER_MILLI - 1));

`ifdef TONE_SEQ_LOOP_EN
    assign loop_active = loop;
`else
    assign loop_active = loop & 1'b0;
`endif

    // Out-of-range channels never report full, so such writes are accepted and dropped.
    always_comb begin
        sel_full = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (wr_chan == CH_W'(c))
                sel_full = full[c];
        end
    end

    assign wr_ready = ena && !stop && !sel_full && !loop_active;
    assign sound    = ^tone;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
        logic [DIV_W-1:0] q_half [DEPTH];
        logic [DUR_W-1:0] q_dur  [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count;
        logic [0:0]       state;
        logic [DIV_W-1:0] cur_half;
        logic [DIV_W-1:0] per_cnt;
        logic [DUR_W-1:0] dur_cnt;
        logic             tone_r;
        logic [DIV_W-1:0] head_half;
        logic [DUR_W-1:0] head_dur;
        logic             push;
        logic             pop;
        logic             requeue;
        logic             note_end;
        logic             load;
        logic             fill;

        assign full[g]   = (count == CNT_W'(DEPTH));
        assign head_half = q_half[rd_ptr];
        assign head_dur  = q_dur[rd_ptr];
        assign push      = wr_valid && wr_ready && (wr_chan == CH_W'(g));
        assign note_end  = (state == ST_PLAY) && ms_tick && (dur_cnt == DUR_W'(1));
        assign pop       = ena && !stop && (count != '0) && ((state == ST_IDLE) || note_end);
        assign requeue   = pop && loop_active;
        assign load      = pop && (head_dur != '0);
        assign fill      = push || requeue;

        // In replay mode the popped head is written back to the tail on the same edge.
        always_ff @(posedge clk) begin
            if (push) begin
                q_half[wr_ptr] <= wr_half_period;
                q_dur[wr_ptr]  <= wr_dur_ms;
            end else if (requeue) begin
                q_half[wr_ptr] <= head_half;
                q_dur[wr_ptr]  <= head_dur;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                state    <= ST_IDLE;
                cur_half <= '0;
                per_cnt  <= '0;
                dur_cnt  <= '0;
                tone_r   <= 1'b0;
            end else if (ena) begin
                if (stop) begin
                    rd_ptr   <= '0;
                    wr_ptr   <= '0;
                    count    <= '0;
                    state    <= ST_IDLE;
                    cur_half <= '0;
                    per_cnt  <= '0;
                    dur_cnt  <= '0;
                    tone_r   <= 1'b0;
                end else begin
                    if (fill)
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    if (pop)
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    if (fill && !pop)
                        count <= count + CNT_W'(1);
                    else if (pop && !fill)
                        count <= count - CNT_W'(1);

                    if (load) begin
                        state    <= ST_PLAY;
                        cur_half <= head_half;
                        per_cnt  <= '0;
                        dur_cnt  <= head_dur;
                        tone_r   <= 1'b0;
                    end else if ((state == ST_IDLE) || note_end) begin
                        // Zero-length entries are discarded here; the next one is looked at next cycle.
                        state  <= ST_IDLE;
                        tone_r <= 1'b0;
                    end else begin
                        if (ms_tick)
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        if (cur_half == '0) begin
                            per_cnt <= '0;
                            tone_r  <= 1'b0;
                        end else if (per_cnt == cur_half - DIV_W'(1)) begin
                            per_cnt <= '0;
                            tone_r  <= ~tone_r;
                        end else begin
                            per_cnt <= per_cnt + DIV_W'(1);
                        end
                    end
                end
            end
        end

        assign tone[g] = tone_r;
        assign busy[g] = (state == ST_PLAY);
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboarded random + directed bench for tone_sequencer against a note-level
// reference model (queues of notes, tone phase computed arithmetically from load time).
module tb_tone_sequencer;

    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int T     = 4;

    typedef struct packed {
        logic [11:0] half;
        logic [7:0]  dur;
    } note_t;

    typedef struct packed {
        logic [1:0] tone;
        logic [1:0] busy;
        logic       sound;
        logic       ready;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        stop;
    logic        loop;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_chan;
    logic [11:0] wr_half_period;
    logic [7:0]  wr_dur_ms;
    logic [1:0]  tone;
    logic [1:0]  busy;
    logic        sound;

    int n_vec = 0;
    int n_bad = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    note_t  mq [CH][$];
    bit     m_play [CH];
    int     m_half [CH];
    longint m_L [CH];
    longint m_E [CH];
    longint K;

    tone_sequencer #(
        .CHANNELS(CH),
        .DEPTH(DEPTH),
        .DIV_W(12),
        .DUR_W(8),
        .TICKS_PER_MILLI(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .stop(stop),
        .loop(loop),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_chan(wr_chan),
        .wr_half_period(wr_half_period),
        .wr_dur_ms(wr_dur_ms),
        .tone(tone),
        .busy(busy),
        .sound(sound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit loop_mode();
`ifdef TONE_SEQ_LOOP_EN
        return loop;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        if (!ena || stop || loop_mode())
            return 1'b0;
        if (int'(wr_chan) >= CH)
            return 1'b1;
        return mq[wr_chan].size() < DEPTH;
    endfunction

    function automatic void model_reset();
        K = 0;
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            m_play[c] = 1'b0;
            m_half[c] = 0;
            m_L[c] = 0;
            m_E[c] = 0;
        end
    endfunction

    // One clock edge of the reference: pops use the pre-edge queues, then the accepted write lands.
    function automatic void model_edge();
        bit    acc;
        bit    lp;
        bit    take;
        note_t n;
        if (!rst_n || !ena)
            return;
        acc = wr_valid && model_ready();
        lp  = loop_mode();
        K++;
        if (stop) begin
            for (int c = 0; c < CH; c++) begin
                mq[c].delete();
                m_play[c] = 1'b0;
            end
            return;
        end
        for (int c = 0; c < CH; c++) begin
            take = 1'b0;
            if (!m_play[c]) begin
                take = (mq[c].size() != 0);
            end else if (K == m_E[c]) begin
                m_play[c] = 1'b0;
                take = (mq[c].size() != 0);
            end
            if (take) begin
                n = mq[c].pop_front();
                if (lp)
                    mq[c].push_back(n);
                if (n.dur != 0) begin
                    m_play[c] = 1'b1;
                    m_half[c] = int'(n.half);
                    m_L[c]    = K;
                    m_E[c]    = (K / T + longint'(n.dur)) * T;
                end
            end
        end
        if (acc && int'(wr_chan) < CH)
            mq[wr_chan].push_back(note_t'{wr_half_period, wr_dur_ms});
    endfunction

    function automatic void push_expect();
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            e.busy[c] = m_play[c];
            e.tone[c] = m_play[c] && (m_half[c] != 0) && ((((K - m_L[c]) / m_half[c]) % 2) == 1);
        end
        e.sound = ^e.tone;
        e.ready = model_ready();
        exp_q.push_back(e);
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            check("tone", {2'b00, tone}, {2'b00, mon_e.tone});
            check("busy", {2'b00, busy}, {2'b00, mon_e.busy});
            check("sound", {3'b000, sound}, {3'b000, mon_e.sound});
            check("wr_ready", {3'b000, wr_ready}, {3'b000, mon_e.ready});
        end
    end

    task automatic cycle();
        push_expect();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic write_note(input int c, input int h, input int d);
        bit ok;
        ok = 1'b0;
        wr_valid       = 1'b1;
        wr_chan        = 1'(c);
        wr_half_period = 12'(h);
        wr_dur_ms      = 8'(d);
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = model_ready();
            cycle();
        end
        wr_valid = 1'b0;
        if (!ok) begin
            n_bad++;
            $display("FAIL write_accept ch%0d: accepted 0 required 1", c);
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        stop = 1'b0;
        loop = 1'b0;
        wr_valid = 1'b0;
        wr_chan = 1'b0;
        wr_half_period = '0;
        wr_dur_ms = '0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst_n = 1'b1;
        idle(2);

        // single note
        write_note(0, 3, 2);
        idle(16);

        // back-pressure on ch1 while it plays a long note
        write_note(1, 1, 10);
        idle(2);
        for (int i = 0; i < 4; i++) write_note(1, 2, 1);
        wr_chan = 1'b0;
        idle(2);
        wr_chan = 1'b1;
        idle(2);
        write_note(1, 3, 1);
        idle(60);

        // gapless, rest, discard
        write_note(0, 2, 1);
        write_note(0, 0, 1);
        write_note(0, 5, 0);
        write_note(0, 4, 1);
        idle(30);

        // mixing, then stop flushes queued notes
        write_note(0, 2, 3);
        write_note(1, 3, 3);
        write_note(0, 1, 2);
        write_note(1, 2, 2);
        idle(8);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        idle(6);

        // reset in the middle of a note
        write_note(0, 2, 5);
        write_note(0, 3, 2);
        idle(6);
        apply_reset(2);
        idle(4);

`ifdef TONE_SEQ_LOOP_EN
        write_note(0, 1, 1);
        write_note(0, 2, 2);
        loop = 1'b1;
        idle(60);
        loop = 1'b0;
        idle(40);
`endif

        // freeze with ena low mid-note
        write_note(1, 2, 3);
        idle(3);
        ena = 1'b0;
        idle(5);
        ena = 1'b1;
        idle(20);

        for (int i = 0; i < 1500; i++) begin
            ena            = ($urandom_range(19) != 0);
            stop           = ($urandom_range(149) == 0);
            wr_valid       = ($urandom_range(2) == 0);
            wr_chan        = 1'($urandom_range(1));
            wr_half_period = 12'($urandom_range(5));
            wr_dur_ms      = 8'($urandom_range(3));
            cycle();
        end
        ena = 1'b1;
        stop = 1'b0;
        idle(60);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: left %0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
